// File: rtl/config_pkg.sv
// Shared definitions for the tile configuration path: module ids, address
// field bounds, end-marker default and the loader state encoding.
package config_pkg;
    localparam logic [15:0] MOD_CLB = 16'd4;
    localparam logic [15:0] MOD_CB1 = 16'd5;
    localparam logic [15:0] MOD_CB0 = 16'd6;
    localparam logic [15:0] MOD_SB  = 16'd7;

    localparam int TILE_ID_LSB = 0;
    localparam int TILE_ID_MSB = 15;
    localparam int MOD_ID_LSB  = 16;
    localparam int MOD_ID_MSB  = 31;

    localparam logic [31:0] END_MARKER_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } load_state_t;
endpackage

// File: rtl/config_record_shift.sv
// Byte-serial assembler for 64-bit little-endian records; the oldest byte
// ends up in bits [7:0] once eight bytes have been shifted in.
module config_record_shift (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [63:0] assembled,
    output logic        full
);
    logic [63:0] record_q;
    logic [2:0]  count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            record_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            record_q <= '0;
            count_q  <= '0;
        end else if (shift) begin
            record_q <= assembled;
            count_q  <= count_q + 3'd1;
        end
    end

    // Includes the byte being accepted now, so the parent sees the whole
    // record on the same edge that byte 7 lands; the counter wraps to 0.
    assign assembled = {byte_in, record_q[63:8]};
    assign full      = shift && (count_q == 3'd7);
endmodule

// File: rtl/config_stream_loader.sv
// Configuration master: assembles records from the byte stream and issues
// each one on the shared config bus for a single cycle.
//   state    | meaning
//   ST_RECV  | accepting bytes, bus parked
//   ST_WRITE | record on the bus for one cycle
//   ST_DONE  | end marker seen, waiting for start
module config_stream_loader
    import config_pkg::*;
#(
    parameter logic [15:0] IDLE_MOD_ID = 16'h0000,
    parameter logic [31:0] END_MARKER  = END_MARKER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        done,
    output logic [15:0] write_count
);
    localparam logic [31:0] PARK_ADDR = {IDLE_MOD_ID, 16'h0000};

    load_state_t state, next_state;
    logic [31:0] next_addr, next_data;
    logic        next_done;
    logic [15:0] next_count;
    logic        shift, clear, full;
    logic [63:0] assembled;

    config_record_shift u_shift (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .shift     (shift),
        .byte_in   (in_data),
        .assembled (assembled),
        .full      (full)
    );

    assign in_ready = (state == ST_RECV);
    assign shift    = in_ready && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RECV;
            config_addr <= PARK_ADDR;
            config_data <= '0;
            done        <= 1'b0;
            write_count <= '0;
        end else begin
            state       <= next_state;
            config_addr <= next_addr;
            config_data <= next_data;
            done        <= next_done;
            write_count <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        next_addr  = PARK_ADDR;
        next_data  = '0;
        next_done  = done;
        next_count = write_count;
        clear      = 1'b0;
        case (state)
            ST_RECV: begin
                if (full) begin
                    if (assembled[31:0] == END_MARKER) begin
                        next_state = ST_DONE;
                        next_done  = 1'b1;
                    end else begin
                        next_state = ST_WRITE;
                        next_addr  = {assembled[MOD_ID_MSB:MOD_ID_LSB],
                                      assembled[TILE_ID_MSB:TILE_ID_LSB]};
                        next_data  = assembled[63:32];
                    end
                end
            end
            ST_WRITE: begin
                next_state = ST_RECV;
                if (write_count != 16'hFFFF)
                    next_count = write_count + 16'd1;
            end
            ST_DONE: begin
                if (start) begin
                    next_state = ST_RECV;
                    next_done  = 1'b0;
                    next_count = '0;
                    clear      = 1'b1;
                end
            end
            default: next_state = ST_RECV;
        endcase
    end
endmodule

// File: tb/tb_config_stream_loader.sv
// Randomized bench for config_stream_loader, compared cycle by cycle against
// a byte-queue reference model.
module tb_config_stream_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] config_addr, config_data;
    logic        done;
    logic [15:0] write_count;

    int total = 0;
    int bad = 0;

    // reference model
    logic [7:0]  m_buf[$];
    bit          m_write, m_done;
    logic [15:0] m_cnt;
    logic [31:0] m_addr, m_data;

    localparam logic [31:0] PARK = 32'h0000_0000;
    localparam logic [31:0] ENDM = 32'hFFFF_FFFF;

    config_stream_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .config_addr (config_addr),
        .config_data (config_data),
        .done        (done),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_write = 0;
        m_done  = 0;
        m_cnt   = '0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    task automatic compare_all();
        chk("config_addr", config_addr, m_write ? m_addr : PARK);
        chk("config_data", config_data, m_write ? m_data : 32'h0);
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("write_count", {16'b0, write_count}, {16'b0, m_cnt});
        chk("in_ready", {31'b0, in_ready}, {31'b0, !(m_write || m_done)});
    endtask

    // one clock: advance model on the edge, compare 1 time unit later
    task automatic step(output bit acc);
        logic [31:0] a;
        @(posedge clk);
        acc = in_valid && !m_write && !m_done;
        if (m_write) begin
            m_write = 0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (m_done) begin
            if (start) begin
                m_done = 0;
                m_cnt  = '0;
            end
        end else if (acc) begin
            m_buf.push_back(in_data);
            if (m_buf.size() == 8) begin
                a = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                if (a == ENDM) m_done = 1;
                else begin
                    m_write = 1;
                    m_addr  = a;
                    m_data  = {m_buf[7], m_buf[6], m_buf[5], m_buf[4]};
                end
                m_buf.delete();
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        while ($urandom_range(0, 99) < gap) begin
            in_valid = 0;
            step(acc);
        end
        in_valid = 1;
        in_data  = b;
        acc = 0;
        n = 0;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input int gap);
        logic [63:0] r;
        r = {d, a};
        for (int i = 0; i < 8; i++) send_byte(r[i*8 +: 8], gap);
    endtask

    task automatic pulse_start();
        bit acc;
        in_valid = 0;
        start = 1;
        step(acc);
        start = 0;
    endtask

    task automatic mid_reset();
        in_valid = 0;
        #2 reset = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 reset = 0;
        compare_all();
    endtask

    logic [31:0] ra, rd;
    bit acc0;

    initial begin
        model_reset();
        #12;
        compare_all();
        @(posedge clk);
        #1 reset = 0;
        compare_all();

        // basic record
        send_rec(32'h0005_0010, 32'h0000_0005, 0);
        idle(3);
        chk("wc_after_first", {16'b0, write_count}, 32'd1);

        // three back-to-back records
        send_rec(32'h0004_0001, 32'hDEAD_BEEF, 0);
        send_rec(32'h0006_0002, 32'h1234_5678, 0);
        send_rec(32'h0007_0003, 32'hA5A5_5A5A, 0);
        idle(3);
        chk("wc_after_b2b", {16'b0, write_count}, 32'd4);

        // gapped record, then address equal to park value
        send_rec(32'h0005_ABCD, 32'h0000_00FF, 60);
        send_rec(32'h0000_0000, 32'h0000_0001, 20);
        idle(2);

        // end marker then restart
        send_rec(32'h0007_0009, 32'h0000_0077, 0);
        send_rec(ENDM, 32'h0, 0);
        idle(5);
        chk("done_set", {31'b0, done}, 32'd1);
        pulse_start();
        chk("done_cleared", {31'b0, done}, 32'd0);
        chk("wc_cleared", {16'b0, write_count}, 32'd0);
        send_rec(32'h0006_0042, 32'h0000_0003, 10);
        idle(2);

        // reset after byte 5 of a record
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 0);
        mid_reset();
        send_rec(32'h0004_0011, 32'h0000_0022, 0);
        idle(2);

        // saturation
        idle(1);
        force dut.write_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        step(acc0);
        release dut.write_count;
        send_rec(32'h0005_0020, 32'h0000_0009, 0);
        idle(2);
        chk("wc_saturated", {16'b0, write_count}, 32'h0000_FFFF);

        // random traffic, with stray start pulses and occasional end markers
        for (int k = 0; k < 40; k++) begin
            ra = $urandom();
            rd = $urandom();
            if (ra == ENDM) ra = 32'h0001_0001;
            if ($urandom_range(0, 9) == 0) ra = ENDM;
            if ($urandom_range(0, 5) == 0) begin
                start = 1;
                send_byte(ra[7:0], 0);
                start = 0;
                for (int i = 1; i < 8; i++) send_byte(8'({rd, ra} >> (i * 8)), $urandom_range(0, 40));
            end else begin
                send_rec(ra, rd, $urandom_range(0, 40));
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            if (m_done) begin
                idle($urandom_range(1, 4));
                pulse_start();
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/config_stream_loader.md
# config_stream_loader

Configuration master for the tile array: accepts a byte-serial bitstream, assembles 64-bit (address, data) records, and drives each one onto the shared `config_addr`/`config_data` bus for exactly one cycle. It is the write side of the per-tile address-matcher configuration path. Between writes the bus carries a parked address that no tile module matches. An end-marker record stops loading and raises `done`.

## Interface
Parameters:
- `IDLE_MOD_ID`, default 0: value of `config_addr[31:16]` while no write is in progress. No tile module decodes it.
- `END_MARKER`, default 32'hFFFF_FFFF: record address that terminates the stream.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: single-cycle pulse that re-arms the loader from DONE.
- `in_data`  in  8: bitstream byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `config_addr`  out  32: field [31:16] is the module id, field [15:0] is the tile id.
- `config_data`  out  32: configuration payload; tiles slice the low bits.
- `done`  out  1: end marker has been consumed.
- `write_count`  out  16: number of writes issued since reset or `start`; saturates.

## Operation
- A record is 8 bytes, little-endian: bytes 0–3 form the address, bytes 4–7 form the data.
- A byte is accepted on any cycle where `in_valid && in_ready` is true.
- FSM states:
  - RECV: `in_ready`=1. A 3-bit byte counter advances on each accept. On the accept of byte 7:
    - address == `END_MARKER` → DONE.
    - otherwise → WRITE.
  - WRITE: lasts one cycle. `in_ready`=0. `config_addr`/`config_data` carry the record. `write_count` increments unless already 16'hFFFF. Next state is RECV with the byte counter at 0.
  - DONE: `in_ready`=0, `done`=1, bus parked. `start` → RECV, `write_count` cleared, `done` cleared.
- `start` has no effect outside DONE.
- Bus parking, in every non-WRITE cycle:
  - `config_addr` = {`IDLE_MOD_ID`, 16'h0000}.
  - `config_data` = 32'h0.
- Address and data change in the same edge, so a tile's address match and its data slice are always coherent.
- No validation of module id or tile id is performed. Any address other than the end marker is issued as-is, including an address equal to the park value.
- Gaps in `in_valid` are allowed anywhere inside a record. The partially assembled record is held indefinitely.

## Timing
- Reset values: state RECV, byte counter 0, `in_ready`=1, `config_addr`={`IDLE_MOD_ID`,16'h0}, `config_data`=0, `done`=0, `write_count`=0.
- `config_addr`, `config_data`, `done` and `write_count` are registered. `in_ready` is decoded from state only and never depends on `in_valid`.
- Byte 7 accepted at edge N:
  - Cycles N→N+1: write visible on the bus; `write_count` shows the new value after edge N+1.
  - Edge N+1: bus parks again and `in_ready` returns to 1.
- Peak rate is one record per 9 cycles.
- End marker accepted at edge N: `done`=1 and `in_ready`=0 from edge N. The bus never carries the marker.
- `reset` asserted mid-record: all state returns to reset values immediately and asynchronously. The partial record is discarded and the bus parks within the same cycle.
- `start` is sampled on the edge. The first byte can be accepted on the next edge.

## Structure
- Shared package `config_pkg` holds:
  - module-id constants: CLB=4, CB1=5, CB0=6, SB=7;
  - field bounds: `TILE_ID_LSB`=0, `TILE_ID_MSB`=15, `MOD_ID_LSB`=16, `MOD_ID_MSB`=31;
  - `END_MARKER` default;
  - FSM state enum.
- One sub-module, `config_record_shift`: a 64-bit byte-shift assembler with byte counter, plus `clear` and `full` signals. The parent holds the FSM and the bus registers.

## Test plan
- After reset, send record 10 00 05 00 | 05 00 00 00 → exactly one cycle with `config_addr`=32'h0005_0010 and `config_data`=32'h5. `write_count`=1. Bus is 32'h0 before and after.
- Send 3 back-to-back records with `in_valid` held at 1 → writes appear 9 cycles apart and `in_ready` is low only in WRITE cycles. `write_count`=3.
- Insert random `in_valid` gaps inside a record → bus shows a single correct write after the 8th byte; no early or extra writes.
- Send one record, then the FF×4 end marker followed by 00×4 → `done`=1 and `in_ready`=0, the bus never shows FFFF_FFFF, and `write_count` stays 1. Pulse `start` → `done`=0, `write_count`=0, and the next record loads.
- Assert `reset` after byte 5 of a record → outputs return to reset values asynchronously. A fresh full record afterwards writes correctly with no residue.
- Force `write_count` to 16'hFFFF, then send one more record → the write still appears on the bus and the count stays at 16'hFFFF.
